// File: rtl/zxmmc_pkg.sv
// Shared constants and state encoding for the ZXMMC SPI initiator.
package zxmmc_pkg;

  // Default low address bytes of the ZXMMC I/O ports.
  localparam logic [7:0] ZXMMC_PORT_CS   = 8'hE7;
  localparam logic [7:0] ZXMMC_PORT_DATA = 8'hEB;

  // One SPI byte is 8 SCK periods, i.e. 16 half-period phases.
  localparam int SPI_PHASES = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spiState;

endpackage

// File: rtl/spi_byte.sv
// Mode-0 SPI byte shifter: sends tx MSB first, collects rx, one phase per ce.
module spi_byte
  import zxmmc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       start,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       done,
  output logic       busy,
  output logic       spiCk,
  output logic       spiMosi,
  input  logic       spiMiso
);

  localparam logic [3:0] LAST_PHASE = 4'(SPI_PHASES - 1);

  spiState     state, stateNext;
  logic [3:0]  phase, phaseNext;
  logic [7:0]  txShift, txShiftNext;
  logic [7:0]  rxShift, rxShiftNext;
  logic        ckNext;

  // State register; everything else is computed in the next-state block.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= '0;
      txShift <= 8'hFF;
      rxShift <= 8'hFF;
      spiCk   <= 1'b0;
    end else begin
      state   <= stateNext;
      phase   <= phaseNext;
      txShift <= txShiftNext;
      rxShift <= rxShiftNext;
      spiCk   <= ckNext;
    end
  end

  // Next-state logic: rise and sample on even phases, fall and shift on odd.
  // NOTE: every output of this block gets a default first; otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    stateNext   = state;
    phaseNext   = phase;
    txShiftNext = txShift;
    rxShiftNext = rxShift;
    ckNext      = spiCk;
    done        = 1'b0;
    case (state)
      IDLE: begin
        // A ce arriving together with start is not consumed as phase 0.
        if (start) begin
          stateNext   = SHIFT;
          phaseNext   = '0;
          txShiftNext = tx;
          ckNext      = 1'b0;
        end
      end
      SHIFT: begin
        if (ce) begin
          phaseNext = phase + 4'd1;
          if (!phase[0]) begin
            ckNext = 1'b1;
            rxShiftNext[3'd7 - phase[3:1]] = spiMiso;
          end else begin
            ckNext      = 1'b0;
            txShiftNext = {txShift[6:0], 1'b1};
            if (phase == LAST_PHASE) begin
              stateNext = IDLE;
              done      = 1'b1;
            end
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bit 0 is sampled on phase 14, so rxShift is complete when done fires.
  assign rx      = rxShift;
  assign busy    = (state == SHIFT);
  assign spiMosi = (state == SHIFT) ? txShift[7] : 1'b1;

endmodule

// File: rtl/zxmmc_spi.sv
// ZXMMC Z80 port decoder, chip-select register and SPI byte initiator.
module zxmmc_spi
  import zxmmc_pkg::*;
#(
  parameter logic [7:0] PORT_CS   = ZXMMC_PORT_CS,
  parameter logic [7:0] PORT_DATA = ZXMMC_PORT_DATA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       iorq,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] a,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       sel,
  output logic       busy,
  output logic       spiCs,
  input  logic       spiMiso,
  output logic       spiCk,
  output logic       spiMosi
);

  logic       acc, accReg, accEvent;
  logic       csWrite, dataWrite, dataRead;
  logic       start, done;
  logic [7:0] tx, rx;

  // One event per bus cycle: the first clock on which the access is seen.
  assign acc       = ~iorq & (~rd | ~wr);
  assign accEvent  = acc & ~accReg;
  assign csWrite   = accEvent & ~wr & (a == PORT_CS);
  assign dataWrite = accEvent & ~wr & (a == PORT_DATA);
  assign dataRead  = accEvent & ~rd & (a == PORT_DATA);

  // Accesses to the data port while busy are dropped; a read clocks out FFs.
  assign start = (dataWrite | dataRead) & ~busy;
  assign tx    = dataWrite ? d : 8'hFF;

  assign sel = ~iorq & ~rd & (a == PORT_DATA);

  // Bus-access edge detector, chip-select latch and received-byte register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accReg <= 1'b0;
      spiCs  <= 1'b1;
      q      <= 8'hFF;
    end else begin
      accReg <= acc;
      if (csWrite) spiCs <= d[0];
      if (done)    q     <= rx;
    end
  end

  spi_byte u_spiByte (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .start   (start),
    .tx      (tx),
    .rx      (rx),
    .done    (done),
    .busy    (busy),
    .spiCk   (spiCk),
    .spiMosi (spiMosi),
    .spiMiso (spiMiso)
  );

endmodule

// File: tb/tb_zxmmc_spi.sv
// Self-checking bench for zxmmc_spi with a behavioural SD-card byte model.
module tb_zxmmc_spi;

  logic       clock = 1'b0;
  logic       reset, ce, iorq, rd, wr;
  logic [7:0] a, d, q;
  logic       sel, busy, spiCs, spiCk, spiMosi, spiMiso;

  int total = 0;
  int bad   = 0;

  // Card model state: byte to return and SCK rise bookkeeping.
  logic [7:0] cardTx  = 8'hFF;
  logic [7:0] mosiLog = 8'hFF;
  logic [7:0] modelQ  = 8'hFF;
  int         riseCount   = 0;
  int         riseBase    = 0;
  int         ceBusyTotal = 0;
  int         misoIdx;
  bit         ceEnable = 1'b0;

  zxmmc_spi dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .iorq    (iorq),
    .rd      (rd),
    .wr      (wr),
    .a       (a),
    .d       (d),
    .q       (q),
    .sel     (sel),
    .busy    (busy),
    .spiCs   (spiCs),
    .spiMiso (spiMiso),
    .spiCk   (spiCk),
    .spiMosi (spiMosi)
  );

  always #5 clock = ~clock;

  // Card presents bit (7 - rises so far) MSB first; idles high.
  always_comb begin
    misoIdx = riseCount - riseBase;
    spiMiso = (misoIdx >= 0 && misoIdx < 8) ? cardTx[7 - misoIdx] : 1'b1;
  end

  // Count SCK rises and capture MOSI on each rise.
  always @(posedge spiCk) begin
    riseCount <= riseCount + 1;
    mosiLog   <= {mosiLog[6:0], spiMosi};
  end

  // Count ce ticks consumed while a transfer is running.
  always @(posedge clock) begin
    if (ce && busy) ceBusyTotal <= ceBusyTotal + 1;
  end

  // Irregular ce ticks, driven between clock edges.
  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clock);
      ce = ceEnable && ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic busOpen(input bit isWrite, input logic [7:0] addr, input logic [7:0] data);
    @(negedge clock);
    a = addr;
    d = data;
    iorq = 1'b0;
    if (isWrite) wr = 1'b0;
    else         rd = 1'b0;
  endtask

  task automatic busClose();
    @(negedge clock);
    iorq = 1'b1;
    rd   = 1'b1;
    wr   = 1'b1;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout busy=%b want 0", tag, busy);
    end
  endtask

  task automatic waitCe(input int base, input int count, input string tag);
    int n = 0;
    while ((ceBusyTotal - base) < count && n < 2000) begin
      @(negedge clock);
      n++;
    end
    total++;
    if ((ceBusyTotal - base) < count) begin
      bad++;
      $display("FAIL %s_ce_wait got=%0d want=%0d", tag, ceBusyTotal - base, count);
    end
  endtask

  task automatic test_reset();
    int ceBase;
    total++; if (spiCs !== 1'b1)   begin bad++; $display("FAIL rst_cs got=%b want=1", spiCs); end
    total++; if (spiCk !== 1'b0)   begin bad++; $display("FAIL rst_ck got=%b want=0", spiCk); end
    total++; if (spiMosi !== 1'b1) begin bad++; $display("FAIL rst_mosi got=%b want=1", spiMosi); end
    total++; if (q !== 8'hFF)      begin bad++; $display("FAIL rst_q got=%h want=ff", q); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    // Select the card, start a byte, then reset after 5 ticks.
    busOpen(1'b1, 8'hE7, 8'h00);
    busClose();
    cardTx   = 8'h00;
    riseBase = riseCount;
    ceBase   = ceBusyTotal;
    busOpen(1'b1, 8'hEB, 8'h96);
    busClose();
    waitCe(ceBase, 5, "rst_mid");
    #2 reset = 1'b0;
    #1;
    total++; if (spiCs !== 1'b1)   begin bad++; $display("FAIL rstmid_cs got=%b want=1", spiCs); end
    total++; if (spiCk !== 1'b0)   begin bad++; $display("FAIL rstmid_ck got=%b want=0", spiCk); end
    total++; if (spiMosi !== 1'b1) begin bad++; $display("FAIL rstmid_mosi got=%b want=1", spiMosi); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (q !== 8'hFF)      begin bad++; $display("FAIL rstmid_q got=%h want=ff", q); end
    @(negedge clock);
    reset  = 1'b1;
    modelQ = 8'hFF;
  endtask

  task automatic test_cs_write();
    for (int i = 0; i < 2; i++) begin
      logic want;
      want = (i == 1);
      busOpen(1'b1, 8'hE7, {7'h00, want});
      #1;
      total++; if (spiCs !== ~want) begin bad++; $display("FAIL cs_before_%0d got=%b want=%b", i, spiCs, ~want); end
      @(posedge clock);
      #1;
      total++; if (spiCs !== want) begin bad++; $display("FAIL cs_after_%0d got=%b want=%b", i, spiCs, want); end
      busClose();
    end
  endtask

  task automatic test_write_a5();
    int  ceBase;
    int  n = 0;
    bit  early = 1'b0;
    cardTx   = 8'h3C;
    riseBase = riseCount;
    ceBase   = ceBusyTotal;
    busOpen(1'b1, 8'hEB, 8'hA5);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL a5_busy_event got=%b want=0", busy); end
    total++; if (sel !== 1'b0)  begin bad++; $display("FAIL a5_sel_write got=%b want=0", sel); end
    @(posedge clock);
    #1;
    total++; if (busy !== 1'b1)    begin bad++; $display("FAIL a5_busy_start got=%b want=1", busy); end
    total++; if (spiMosi !== 1'b1) begin bad++; $display("FAIL a5_mosi_start got=%b want=1", spiMosi); end
    busClose();
    while (busy && n < 3000) begin
      if (q !== modelQ) early = 1'b1;
      @(negedge clock);
      n++;
    end
    total++; if (early)         begin bad++; $display("FAIL a5_q_early got=1 want=0"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL a5_timeout busy=%b want 0", busy); end
    total++; if (mosiLog !== 8'hA5) begin bad++; $display("FAIL a5_mosi got=%h want=a5", mosiLog); end
    total++; if (riseCount - riseBase != 8) begin bad++; $display("FAIL a5_sck got=%0d want=8", riseCount - riseBase); end
    total++; if (ceBusyTotal - ceBase != 16) begin bad++; $display("FAIL a5_ce got=%0d want=16", ceBusyTotal - ceBase); end
    total++; if (q !== 8'h3C)       begin bad++; $display("FAIL a5_q got=%h want=3c", q); end
    total++; if (spiMosi !== 1'b1)  begin bad++; $display("FAIL a5_mosi_idle got=%b want=1", spiMosi); end
    total++; if (spiCk !== 1'b0)    begin bad++; $display("FAIL a5_ck_idle got=%b want=0", spiCk); end
    modelQ = 8'h3C;
  endtask

  task automatic test_read_twice();
    logic [7:0] cards [2];
    int         rb;
    cards[0] = 8'h5A;
    cards[1] = 8'hC3;
    for (int i = 0; i < 2; i++) begin
      cardTx   = cards[i];
      riseBase = riseCount;
      busOpen(1'b0, 8'hEB, 8'h00);
      #1;
      total++; if (sel !== 1'b1)  begin bad++; $display("FAIL rd%0d_sel got=%b want=1", i, sel); end
      total++; if (q !== modelQ)  begin bad++; $display("FAIL rd%0d_q got=%h want=%h", i, q, modelQ); end
      busClose();
      waitIdle("rd");
      total++; if (mosiLog !== 8'hFF)  begin bad++; $display("FAIL rd%0d_mosi got=%h want=ff", i, mosiLog); end
      total++; if (q !== cards[i])     begin bad++; $display("FAIL rd%0d_after got=%h want=%h", i, q, cards[i]); end
      modelQ = cards[i];
    end
    // A read of an unrelated port is not selected and starts nothing.
    rb = riseCount;
    busOpen(1'b0, 8'hE7, 8'h00);
    #1;
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL other_sel got=%b want=0", sel); end
    busClose();
    repeat (60) @(negedge clock);
    total++; if (riseCount != rb) begin bad++; $display("FAIL other_sck got=%0d want=0", riseCount - rb); end
  endtask

  task automatic test_write_while_busy();
    int ceBase;
    cardTx   = 8'($urandom);
    riseBase = riseCount;
    ceBase   = ceBusyTotal;
    busOpen(1'b1, 8'hEB, 8'hA5);
    busClose();
    waitCe(ceBase, 4, "wwb");
    busOpen(1'b1, 8'hEB, 8'h12);
    busClose();
    waitIdle("wwb");
    total++; if (mosiLog !== 8'hA5) begin bad++; $display("FAIL wwb_mosi got=%h want=a5", mosiLog); end
    total++; if (q !== cardTx)      begin bad++; $display("FAIL wwb_q got=%h want=%h", q, cardTx); end
    repeat (100) @(negedge clock);
    total++; if (riseCount - riseBase != 8) begin bad++; $display("FAIL wwb_sck got=%0d want=8", riseCount - riseBase); end
    modelQ = cardTx;
  endtask

  task automatic test_long_bus_cycle();
    logic [7:0] data;
    data     = 8'($urandom);
    cardTx   = 8'($urandom);
    riseBase = riseCount;
    busOpen(1'b1, 8'hEB, data);
    repeat (19) @(negedge clock);
    busClose();
    waitIdle("long");
    repeat (100) @(negedge clock);
    total++; if (riseCount - riseBase != 8) begin bad++; $display("FAIL long_sck got=%0d want=8", riseCount - riseBase); end
    total++; if (mosiLog !== data) begin bad++; $display("FAIL long_mosi got=%h want=%h", mosiLog, data); end
    total++; if (q !== cardTx)     begin bad++; $display("FAIL long_q got=%h want=%h", q, cardTx); end
    modelQ = cardTx;
  endtask

  task automatic test_ce_stall();
    logic [7:0] data;
    logic       ckHold;
    int         riseHold, ceBase;
    data     = 8'($urandom);
    cardTx   = 8'($urandom);
    riseBase = riseCount;
    ceBase   = ceBusyTotal;
    busOpen(1'b1, 8'hEB, data);
    busClose();
    waitCe(ceBase, 7, "stall");
    ceEnable = 1'b0;
    repeat (2) @(negedge clock);
    ckHold   = spiCk;
    riseHold = riseCount;
    repeat (50) @(negedge clock);
    total++; if (spiCk !== ckHold)   begin bad++; $display("FAIL stall_ck got=%b want=%b", spiCk, ckHold); end
    total++; if (riseCount != riseHold) begin bad++; $display("FAIL stall_sck got=%0d want=%0d", riseCount, riseHold); end
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL stall_busy got=%b want=1", busy); end
    ceEnable = 1'b1;
    waitIdle("stall");
    total++; if (ceBusyTotal - ceBase != 16) begin bad++; $display("FAIL stall_ce got=%0d want=16", ceBusyTotal - ceBase); end
    total++; if (mosiLog !== data) begin bad++; $display("FAIL stall_mosi got=%h want=%h", mosiLog, data); end
    total++; if (q !== cardTx)     begin bad++; $display("FAIL stall_q got=%h want=%h", q, cardTx); end
    modelQ = cardTx;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int         op;
      int         hold;
      logic [7:0] data;
      logic [7:0] wantTx;
      op   = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      data = 8'($urandom);
      if (op == 0) begin
        busOpen(1'b1, 8'hE7, data);
        repeat (hold) @(negedge clock);
        busClose();
        total++; if (spiCs !== data[0]) begin bad++; $display("FAIL rnd%0d_cs got=%b want=%b", i, spiCs, data[0]); end
      end else begin
        wantTx   = (op == 1) ? data : 8'hFF;
        cardTx   = 8'($urandom);
        riseBase = riseCount;
        busOpen(op == 1, 8'hEB, data);
        #1;
        if (op == 2) begin
          total++; if (q !== modelQ) begin bad++; $display("FAIL rnd%0d_rdq got=%h want=%h", i, q, modelQ); end
        end
        repeat (hold) @(negedge clock);
        busClose();
        waitIdle("rnd");
        total++; if (mosiLog !== wantTx) begin bad++; $display("FAIL rnd%0d_mosi got=%h want=%h", i, mosiLog, wantTx); end
        total++; if (q !== cardTx)       begin bad++; $display("FAIL rnd%0d_q got=%h want=%h", i, q, cardTx); end
        modelQ = cardTx;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    iorq  = 1'b1;
    rd    = 1'b1;
    wr    = 1'b1;
    a     = 8'h00;
    d     = 8'h00;
    repeat (3) @(negedge clock);
    reset    = 1'b1;
    ceEnable = 1'b1;
    @(negedge clock);
    test_reset();
    test_cs_write();
    test_write_a5();
    test_read_twice();
    test_write_while_busy();
    test_long_bus_cycle();
    test_ce_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
